sha_job_scheduler: RTL and testbench
====================================

SHA_JOB_SCHEDULER -- requirements
Module: sha_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, giving the number of SHA-256 cores driven (range 1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the job descriptor queue depth (power of 2).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 job_valid / job_ready  in / out  1 / 1  job submit handshake; a job is accepted on an edge where both are high.
REQ-006 job_msg_addr / job_out_addr  in  16 / 16  message word address and hash output word address of the submitted job.
REQ-007 core_start  out  NUM_CORES  per-core start pulse.
REQ-008 core_message_addr / core_output_addr  out  NUM_CORES x 16  per-core job addresses, held stable from start until that core completes.
REQ-009 core_done  in  NUM_CORES  per-core done level; high means the core is idle.
REQ-010 cmp_valid / cmp_core_id / cmp_out_addr  out  1 / 3 / 16  one-cycle completion report: which core finished and where its hash was written.
REQ-011 err  out  NUM_CORES  sticky per-core start-timeout flag.
REQ-012 queue_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 idle  out  1  high when FIFO is empty and all slots are FREE.

Function
REQ-014 Jobs SHALL enter a FIFO; job_ready = (queue_count < FIFO_DEPTH), with no bypass path; a full FIFO drops nothing because job_ready is low.
REQ-015 Push and pop in the same cycle SHALL leave queue_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 Each core SHALL have a slot FSM with states FREE, LAUNCH, WAIT_BUSY, RUN and REPORT.
REQ-017 FREE -> LAUNCH on dispatch; LAUNCH asserts core_start for exactly one cycle, then moves to WAIT_BUSY.
REQ-018 WAIT_BUSY -> RUN when core_done is sampled low.
REQ-019 WAIT_BUSY -> FREE with err[i] set when core_done stays high for 4 consecutive cycles; no completion is reported in that case.
REQ-020 RUN -> REPORT when core_done is sampled high; REPORT -> FREE in the cycle its completion is emitted.
REQ-021 At most one dispatch per cycle, when the FIFO is non-empty and at least one slot is FREE.
REQ-022 Dispatch target SHALL be chosen round-robin, starting at the core after the last dispatched one; the pointer advances only on dispatch.
REQ-023 On dispatch the FIFO head SHALL be popped and its addresses registered into that core's core_message_addr / core_output_addr.
REQ-024 Latency: a job accepted at edge T into an empty FIFO with a FREE slot SHALL have core_start high during cycle T+1 to T+2.
REQ-025 Completion arbitration SHALL be fixed priority, lowest index first, one report per cycle; unreported slots stay in REPORT, so no completion is lost.
REQ-026 A slot SHALL NOT be redispatched before its completion is reported.
REQ-027 err[i] SHALL clear only on reset.

Reset
REQ-028 On reset all of the following SHALL be cleared: FIFO empty, queue_count=0, all slots FREE, round-robin pointer=0.
REQ-029 Outputs after reset: core_start=0, cmp_valid=0, cmp_core_id=0, cmp_out_addr=0, core_*_addr=0, err=0, job_ready=1, idle=1.
REQ-030 Reset mid-operation SHALL abandon in-flight jobs without reporting them; the cores must be reset by the same system reset.

Structure
REQ-031 Package sha_sched_pkg SHALL hold the slot state enum, ADDR_W=16, and the start-timeout constant 4.
REQ-032 Sub-module sha_core_slot SHALL implement one slot FSM, its address registers and its timeout counter; it is instantiated NUM_CORES times.

Verification
REQ-033 Single job 0x0000/0x0100 with the core model's done dropping 1 cycle after start and rising 150 cycles later -> start pulse at T+1, exactly one cmp_valid with id 0, out 0x0100, idle=1 afterwards.
REQ-034 Five back-to-back jobs, both cores held busy -> job_ready low after the 4th job is queued (queue_count=4), 5th accepted only after a dispatch, all five completions reported in order of core finish.
REQ-035 Four jobs, instant-idle cores -> dispatch order core 0,1,0,1.
REQ-036 Both cores raise done on the same edge -> cmp for core 0 in that cycle, core 1 in the next, neither redispatched before its report.
REQ-037 Core 1 never drops done -> err[1]=1 five cycles after start, slot FREE, no cmp; reset then clears err.
REQ-038 Reset asserted during RUN -> next cycle all outputs at reset values and queue_count=0.

Source files
------------

// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA-256 job scheduler.
package sha_sched_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned START_TIMEOUT = 4;

  typedef enum logic [2:0] {
    SlotFree,
    SlotLaunch,
    SlotWaitBusy,
    SlotRun,
    SlotReport
  } slot_state_e;

endpackage

// File: rtl/sha_job_scheduler_if.sv
// Job submit and completion report bundle between a host and the scheduler.
interface sha_job_scheduler_if;
  import sha_sched_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_msg_addr;
  logic [ADDR_W-1:0] job_out_addr;
  logic              cmp_valid;
  logic [2:0]        cmp_core_id;
  logic [ADDR_W-1:0] cmp_out_addr;

  modport master (
    output job_valid, job_msg_addr, job_out_addr,
    input  job_ready, cmp_valid, cmp_core_id, cmp_out_addr
  );

  modport slave (
    input  job_valid, job_msg_addr, job_out_addr,
    output job_ready, cmp_valid, cmp_core_id, cmp_out_addr
  );

endinterface

// File: rtl/sha_core_slot.sv
// One per-core slot: launch FSM, job address registers and start-timeout counter.
module sha_core_slot
  import sha_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch,
  input  logic [ADDR_W-1:0] msg_addr,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic              core_done,
  input  logic              report_ack,
  output logic              core_start,
  output logic              is_free,
  output logic              report_req,
  output logic              err,
  output logic [ADDR_W-1:0] core_message_addr,
  output logic [ADDR_W-1:0] core_output_addr
);

  localparam int unsigned CntW = $clog2(START_TIMEOUT + 1);

  slot_state_e       state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] msg_q, out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SlotFree;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      msg_q      <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      if (dispatch) begin
        msg_q <= msg_addr;
        out_q <= out_addr;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      SlotFree:   if (dispatch) state_d = SlotLaunch;
      SlotLaunch: begin
        state_d    = SlotWaitBusy;
        wait_cnt_d = '0;
      end
      SlotWaitBusy: begin
        // A core that never leaves idle is given up on; the slot frees without a report.
        if (!core_done) begin
          state_d = SlotRun;
        end else if (wait_cnt_q == CntW'(START_TIMEOUT - 1)) begin
          state_d = SlotFree;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      SlotRun:    if (core_done) state_d = SlotReport;
      SlotReport: if (report_ack) state_d = SlotFree;
      default:    state_d = SlotFree;
    endcase
  end

  assign core_start        = (state_q == SlotLaunch);
  assign is_free           = (state_q == SlotFree);
  assign report_req        = (state_q == SlotReport);
  assign err               = err_q;
  assign core_message_addr = msg_q;
  assign core_output_addr  = out_q;

endmodule

// File: rtl/sha_job_scheduler.sv
// Queues SHA-256 job descriptors and dispatches them round-robin onto NUM_CORES cores,
// reporting completions one per cycle with lowest-index priority.
module sha_job_scheduler
  import sha_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  sha_job_scheduler_if.slave                  job_if,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0][ADDR_W-1:0]    core_message_addr,
  output logic [NUM_CORES-1:0][ADDR_W-1:0]    core_output_addr,
  input  logic [NUM_CORES-1:0]                core_done,
  output logic [NUM_CORES-1:0]                err,
  output logic [$clog2(FIFO_DEPTH):0]         queue_count,
  output logic                                idle
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SelW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [ADDR_W-1:0]    msg_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    out_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [SelW-1:0]      rr_q, grant_idx, lo_idx, hi_idx;
  logic                 lo_found, hi_found;
  logic                 push, pop;
  logic [NUM_CORES-1:0] slot_free, report_req, report_ack, dispatch;
  logic                 cmp_found;
  logic [2:0]           cmp_id;
  logic [ADDR_W-1:0]    cmp_addr;

  assign job_if.job_ready = (count_q < CntW'(FIFO_DEPTH));
  assign push             = job_if.job_valid && job_if.job_ready;
  assign pop              = (count_q != '0) && lo_found;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        rr_q     <= (grant_idx == SelW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      msg_mem[wr_ptr_q] <= job_if.job_msg_addr;
      out_mem[wr_ptr_q] <= job_if.job_out_addr;
    end
  end

  // Round-robin: lowest free slot at or above rr_q, else wrap to the lowest free slot.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (slot_free[i]) begin
        lo_found = 1'b1;
        lo_idx   = SelW'(i);
        if (SelW'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = SelW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_CORES; i++) begin
      dispatch[i] = pop && (grant_idx == SelW'(i));
    end
  end

  always_comb begin
    cmp_found  = 1'b0;
    cmp_id     = '0;
    cmp_addr   = '0;
    report_ack = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (report_req[i] && !cmp_found) begin
        cmp_found     = 1'b1;
        cmp_id        = 3'(i);
        cmp_addr      = core_output_addr[i];
        report_ack[i] = 1'b1;
      end
    end
  end

  assign job_if.cmp_valid    = cmp_found;
  assign job_if.cmp_core_id  = cmp_id;
  assign job_if.cmp_out_addr = cmp_addr;
  assign queue_count         = count_q;
  assign idle                = (count_q == '0) && (&slot_free);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    sha_core_slot u_slot (
      .clk               (clk),
      .reset             (reset),
      .dispatch          (dispatch[i]),
      .msg_addr          (msg_mem[rd_ptr_q]),
      .out_addr          (out_mem[rd_ptr_q]),
      .core_done         (core_done[i]),
      .report_ack        (report_ack[i]),
      .core_start        (core_start[i]),
      .is_free           (slot_free[i]),
      .report_req        (report_req[i]),
      .err               (err[i]),
      .core_message_addr (core_message_addr[i]),
      .core_output_addr  (core_output_addr[i])
    );
  end

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Directed bench for sha_job_scheduler with a simple behavioural SHA core model per slot.
module tb_sha_job_scheduler;
  import sha_sched_pkg::*;

  localparam int unsigned NC = 2;
  localparam int unsigned FD = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NC-1:0]        core_start;
  logic [NC-1:0]        core_done = '1;
  logic [NC-1:0][15:0]  cma, coa;
  logic [NC-1:0]        err;
  logic [2:0]           queue_count;
  logic                 idle;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  int unsigned busy_len [NC];
  bit          hang     [NC];
  int unsigned busy_cnt [NC];

  int unsigned cmp_ids[$];
  logic [15:0] cmp_addrs[$];
  int unsigned cmp_cyc[$];
  int unsigned start_ids[$];
  int unsigned start_cyc[$];

  sha_job_scheduler_if jif();

  sha_job_scheduler #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .job_if            (jif),
    .core_start        (core_start),
    .core_message_addr (cma),
    .core_output_addr  (coa),
    .core_done         (core_done),
    .err               (err),
    .queue_count       (queue_count),
    .idle              (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done drops after a start and rises busy_len cycles later; hang keeps it high.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (reset) begin
        core_done[i] <= 1'b1;
        busy_cnt[i]  <= 0;
      end else if (core_start[i] && !hang[i]) begin
        core_done[i] <= 1'b0;
        busy_cnt[i]  <= busy_len[i];
      end else if (busy_cnt[i] != 0) begin
        busy_cnt[i] <= busy_cnt[i] - 1;
        if (busy_cnt[i] == 1) core_done[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (jif.cmp_valid) begin
        cmp_ids.push_back(int'(jif.cmp_core_id));
        cmp_addrs.push_back(jif.cmp_out_addr);
        cmp_cyc.push_back(cyc);
      end
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          start_ids.push_back(i);
          start_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cmp_ids.delete();
    cmp_addrs.delete();
    cmp_cyc.delete();
    start_ids.delete();
    start_cyc.delete();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    jif.job_valid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      hang[i]     = 1'b0;
      busy_len[i] = 10;
    end
    step(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic push_job(input logic [15:0] m, input logic [15:0] o);
    int unsigned w = 0;
    logic rdy = 1'b0;
    jif.job_valid    = 1'b1;
    jif.job_msg_addr = m;
    jif.job_out_addr = o;
    while (!rdy && w < 500) begin
      @(negedge clk);
      rdy = jif.job_ready;
      @(posedge clk);
      #1;
      w++;
    end
    if (!rdy) check_eq("push_accept", {31'b0, jif.job_ready}, 32'd1);
    jif.job_valid = 1'b0;
  endtask

  task automatic wait_cmps(input string tag, input int unsigned n, input int unsigned budget);
    int unsigned w = 0;
    while (cmp_ids.size() < n && w < budget) begin
      step(1);
      w++;
    end
    check_eq(tag, cmp_ids.size(), n);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_core_start"}, {30'b0, core_start}, 32'd0);
    check_eq({pfx, "_cmp_valid"}, {31'b0, jif.cmp_valid}, 32'd0);
    check_eq({pfx, "_cmp_id"}, {29'b0, jif.cmp_core_id}, 32'd0);
    check_eq({pfx, "_cmp_addr"}, {16'b0, jif.cmp_out_addr}, 32'd0);
    check_eq({pfx, "_msg_addr"}, cma, 32'd0);
    check_eq({pfx, "_out_addr"}, coa, 32'd0);
    check_eq({pfx, "_err"}, {30'b0, err}, 32'd0);
    check_eq({pfx, "_job_ready"}, {31'b0, jif.job_ready}, 32'd1);
    check_eq({pfx, "_idle"}, {31'b0, idle}, 32'd1);
    check_eq({pfx, "_qcount"}, {29'b0, queue_count}, 32'd0);
  endtask

  int unsigned exp_ids [7]   = '{0, 1, 0, 1, 0, 0, 1};
  logic [15:0] exp_addrs [7] = '{16'h2000, 16'h2001, 16'h2010, 16'h2011, 16'h2012, 16'h2014,
                                 16'h2013};
  int unsigned exp_rr [6]    = '{0, 1, 0, 1, 0, 1};

  initial begin
    int unsigned w;
    int unsigned n_starts;
    jif.job_valid    = 1'b0;
    jif.job_msg_addr = '0;
    jif.job_out_addr = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    step(1);

    // Single job: start one cycle after acceptance, one report
    do_reset();
    busy_len[0] = 150;
    busy_len[1] = 150;
    push_job(16'h0000, 16'h0100);
    @(negedge clk);
    check_eq("single_start_T0", {30'b0, core_start}, 32'd0);
    check_eq("single_qcount_T0", {29'b0, queue_count}, 32'd1);
    @(negedge clk);
    check_eq("single_start_T1", {30'b0, core_start}, 32'd1);
    check_eq("single_msg_addr", {16'b0, cma[0]}, 32'h0000);
    check_eq("single_out_addr", {16'b0, coa[0]}, 32'h0100);
    check_eq("single_qcount_T1", {29'b0, queue_count}, 32'd0);
    @(negedge clk);
    check_eq("single_start_T2", {30'b0, core_start}, 32'd0);
    wait_cmps("single_cmp_seen", 1, 300);
    if (cmp_ids.size() >= 1 && start_cyc.size() >= 1) begin
      check_eq("single_cmp_id", cmp_ids[0], 32'd0);
      check_eq("single_cmp_addr", {16'b0, cmp_addrs[0]}, 32'h0100);
      check_eq("single_cmp_latency", cmp_cyc[0] - start_cyc[0], 32'd152);
    end
    step(5);
    check_eq("single_cmp_once", cmp_ids.size(), 32'd1);
    check_eq("single_idle", {31'b0, idle}, 32'd1);

    // Back-to-back jobs against two busy cores: FIFO fills, fifth waits for a dispatch
    do_reset();
    busy_len[0] = 30;
    busy_len[1] = 45;
    push_job(16'h1000, 16'h2000);
    push_job(16'h1001, 16'h2001);
    step(3);
    for (int j = 0; j < 4; j++) push_job(16'h1010 + 16'(j), 16'h2010 + 16'(j));
    @(negedge clk);
    check_eq("b2b_qcount_full", {29'b0, queue_count}, 32'd4);
    check_eq("b2b_ready_low", {31'b0, jif.job_ready}, 32'd0);
    check_eq("b2b_starts_before", start_ids.size(), 32'd2);
    push_job(16'h1014, 16'h2014);
    check_eq("b2b_dispatch_first", start_ids.size(), 32'd3);
    wait_cmps("b2b_cmp_count", 7, 400);
    for (int i = 0; i < 7 && i < cmp_ids.size(); i++) begin
      check_eq($sformatf("b2b_cmp_id%0d", i), cmp_ids[i], exp_ids[i]);
      check_eq($sformatf("b2b_cmp_addr%0d", i), {16'b0, cmp_addrs[i]}, {16'b0, exp_addrs[i]});
    end

    // Short jobs: round-robin order, then a lone job must still rotate
    do_reset();
    busy_len[0] = 1;
    busy_len[1] = 1;
    for (int j = 0; j < 4; j++) push_job(16'h3000 + 16'(j), 16'h3100 + 16'(j));
    wait_cmps("rr_cmp4", 4, 100);
    step(2);
    push_job(16'h3004, 16'h3104);
    wait_cmps("rr_cmp5", 5, 100);
    step(2);
    push_job(16'h3005, 16'h3105);
    wait_cmps("rr_cmp6", 6, 100);
    check_eq("rr_start_count", start_ids.size(), 32'd6);
    for (int i = 0; i < 6 && i < start_ids.size(); i++) begin
      check_eq($sformatf("rr_order%0d", i), start_ids[i], exp_rr[i]);
    end

    // Simultaneous completion: core 0 reported first, core 1 next, no early redispatch
    do_reset();
    busy_len[0] = 20;
    busy_len[1] = 19;
    push_job(16'h4000, 16'h4100);
    push_job(16'h4001, 16'h4101);
    push_job(16'h4002, 16'h4102);
    w = 0;
    while (!jif.cmp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("same_cmp0_valid", {31'b0, jif.cmp_valid}, 32'd1);
    check_eq("same_cmp0_id", {29'b0, jif.cmp_core_id}, 32'd0);
    check_eq("same_cmp0_addr", {16'b0, jif.cmp_out_addr}, 32'h4100);
    check_eq("same_cmp0_nostart", {30'b0, core_start}, 32'd0);
    @(negedge clk);
    check_eq("same_cmp1_valid", {31'b0, jif.cmp_valid}, 32'd1);
    check_eq("same_cmp1_id", {29'b0, jif.cmp_core_id}, 32'd1);
    check_eq("same_cmp1_addr", {16'b0, jif.cmp_out_addr}, 32'h4101);
    check_eq("same_cmp1_nostart", {30'b0, core_start}, 32'd0);
    @(negedge clk);
    check_eq("same_redispatch", {30'b0, core_start}, 32'd1);
    check_eq("same_cmp_done", {31'b0, jif.cmp_valid}, 32'd0);
    step(1);

    // Core 1 never goes busy: timeout sets a sticky err, no report, reset clears it
    do_reset();
    busy_len[0] = 30;
    hang[1]     = 1'b1;
    push_job(16'h5000, 16'h5100);
    push_job(16'h5001, 16'h5101);
    w = 0;
    while (!core_start[1] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("tmo_start1", {31'b0, core_start[1]}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("tmo_err_before", {30'b0, err}, 32'd0);
    @(negedge clk);
    check_eq("tmo_err_set", {30'b0, err}, 32'd2);
    wait_cmps("tmo_cmp_core0", 1, 100);
    step(10);
    check_eq("tmo_no_cmp1", cmp_ids.size(), 32'd1);
    if (cmp_ids.size() >= 1) check_eq("tmo_cmp_id", cmp_ids[0], 32'd0);
    check_eq("tmo_idle", {31'b0, idle}, 32'd1);
    check_eq("tmo_err_sticky", {30'b0, err}, 32'd2);
    do_reset();
    @(negedge clk);
    check_eq("tmo_err_cleared", {30'b0, err}, 32'd0);
    step(1);

    // Reset in the middle of running jobs abandons them
    do_reset();
    busy_len[0] = 50;
    busy_len[1] = 50;
    for (int j = 0; j < 4; j++) push_job(16'h6000 + 16'(j), 16'h6100 + 16'(j));
    step(10);
    check_eq("midrst_qcount_pre", {29'b0, queue_count}, 32'd2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    clear_logs();
    @(negedge clk);
    check_reset_outputs("midrst");
    step(80);
    n_starts = start_ids.size();
    check_eq("midrst_no_cmp", cmp_ids.size(), 32'd0);
    check_eq("midrst_no_start", n_starts, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
